// File: rtl/galvo_pkg.sv
// rtl/galvo_pkg.sv - shared message layout, FSM encodings and payload type
package galvo_pkg;

   localparam int SEQ_MSB   = 63;
   localparam int Y_LSB     = 40;
   localparam int X_LSB     = 24;
   localparam int PAYLOAD_W = 40;
   localparam int MSG_W     = 64;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   typedef struct packed {
      logic [7:0]  seq;
      logic [15:0] y;
      logic [15:0] x;
   } payload_t;

   // Low 24 bits of the message are reserved and always zero.
   function automatic logic [MSG_W-1:0] pack_msg(input payload_t p);
      logic [MSG_W-1:0] m;
      m                  = '0;
      m[SEQ_MSB -: 8]    = p.seq;
      m[Y_LSB +: 16]     = p.y;
      m[X_LSB +: 16]     = p.x;
      return m;
   endfunction

endpackage

// File: rtl/msg_fifo.sv
// rtl/msg_fifo.sv - synchronous FIFO with registered pointers and combinational head read
module msg_fifo
   import galvo_pkg::*;
#(
   parameter int WIDTH = PAYLOAD_W,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_50m,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_50m) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/galvo_sample_src.sv
// rtl/galvo_sample_src.sv - decimating galvo sample source feeding the arbitrator u_req/u_ack port
module galvo_sample_src
   import galvo_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic              clk_50m,
   input  logic              rst,
   input  logic              en,
   input  logic [7:0]        decim,
   input  logic              smp_valid,
   input  logic [15:0]       smp_x,
   input  logic [15:0]       smp_y,
   output logic              u_req,
   input  logic              u_ack,
   output logic [MSG_W-1:0]  u_msg,
   output logic [AW:0]       fifo_level,
   output logic [15:0]       drop_cnt
);

   logic [7:0]           dcnt;
   logic [7:0]           seq;
   logic [1:0]           state;
   logic                 keep;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 empty;
   payload_t             payload;
   logic [PAYLOAD_W-1:0] head;

   assign keep    = en && smp_valid && (dcnt == 8'd0);
   assign pop     = (state == S_REQ) && u_ack;
   assign push    = keep && (!full || pop);
   assign payload = '{seq: seq, y: smp_y, x: smp_x};

   msg_fifo #(
      .WIDTH (PAYLOAD_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk_50m (clk_50m),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .din     (payload),
      .dout    (head),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level)
   );

   always_ff @(posedge clk_50m) begin
      if (rst || !en) begin
         dcnt <= 8'd0;
      end else if (smp_valid) begin
         dcnt <= (dcnt >= decim) ? 8'd0 : dcnt + 8'd1;
      end
   end

   // seq advances even for dropped samples so the host can see the gap.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         seq <= 8'd0;
      end else if (keep) begin
         seq <= seq + 8'd1;
      end
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         drop_cnt <= 16'd0;
      end else if (keep && !push && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end

   // Waiting for u_ack low in S_IDLE keeps a stale ack from triggering a duplicate.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state <= S_IDLE;
         u_req <= 1'b0;
         u_msg <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!empty && !u_ack) begin
                  u_msg <= pack_msg(payload_t'(head));
                  u_req <= 1'b1;
                  state <= S_REQ;
               end
            end
            S_REQ: begin
               if (u_ack) begin
                  u_req <= 1'b0;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!u_ack) state <= S_IDLE;
            end
            default: begin
               u_req <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_galvo_sample_src.sv
// tb/tb_galvo_sample_src.sv - scoreboard bench for galvo_sample_src
module tb_galvo_sample_src;
   import galvo_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic              clk_50m = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic [7:0]        decim = 8'd0;
   logic              smp_valid = 1'b0;
   logic [15:0]       smp_x = 16'd0;
   logic [15:0]       smp_y = 16'd0;
   logic              u_req;
   logic              u_ack = 1'b0;
   logic [63:0]       u_msg;
   logic [AW:0]       fifo_level;
   logic [15:0]       drop_cnt;

   int                tests = 0;
   int                fails = 0;

   logic [63:0]       exp_q[$];
   logic [7:0]        m_seq;
   int                m_dcnt;
   logic [15:0]       m_drop;

   galvo_sample_src #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk_50m    (clk_50m),
      .rst        (rst),
      .en         (en),
      .decim      (decim),
      .smp_valid  (smp_valid),
      .smp_x      (smp_x),
      .smp_y      (smp_y),
      .u_req      (u_req),
      .u_ack      (u_ack),
      .u_msg      (u_msg),
      .fifo_level (fifo_level),
      .drop_cnt   (drop_cnt)
   );

   always #10 clk_50m = ~clk_50m;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      smp_valid = 1'b0;
      u_ack     = 1'b0;
      @(negedge clk_50m);
      rst = 1'b0;
      exp_q.delete();
      m_seq  = 8'd0;
      m_dcnt = 0;
      m_drop = 16'd0;
   endtask

   // Model of decimation / overflow; extra_room covers a pop landing in the same cycle.
   task automatic model_sample(input logic [15:0] x, input logic [15:0] y, input int extra_room);
      if (en) begin
         if (m_dcnt == 0) begin
            if (exp_q.size() < DEPTH + extra_room) exp_q.push_back({m_seq, y, x, 24'h0});
            else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            m_seq = m_seq + 8'd1;
         end
         m_dcnt = (m_dcnt >= int'(decim)) ? 0 : m_dcnt + 1;
      end else begin
         m_dcnt = 0;
      end
   endtask

   task automatic send_sample(input logic [15:0] x, input logic [15:0] y);
      smp_x     = x;
      smp_y     = y;
      smp_valid = 1'b1;
      model_sample(x, y, 0);
      @(negedge clk_50m);
      smp_valid = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int waited;
      waited = 0;
      while (!u_req && waited < 40) begin
         @(negedge clk_50m);
         waited++;
      end
      check({tag, "_req"}, u_req, 1);
   endtask

   task automatic deliver(input int hold, input string tag);
      logic [63:0] exp;
      wait_req(tag);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      check({tag, "_msg"}, u_msg, exp);
      @(negedge clk_50m);
      check({tag, "_stable"}, u_msg, exp);
      u_ack = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk_50m);
         check({tag, "_req_during_ack"}, u_req, 0);
      end
      u_ack = 1'b0;
      @(negedge clk_50m);
      check({tag, "_gap"}, u_req, 0);
   endtask

   initial begin
      logic        seen;
      logic [63:0] exp;

      // Reset state
      @(negedge clk_50m);
      en    = 1'b1;
      decim = 8'd0;
      do_reset();
      check("rst_u_req", u_req, 0);
      check("rst_u_msg", u_msg, 0);
      check("rst_level", fifo_level, 0);
      check("rst_drop", drop_cnt, 0);

      // Single sample: request two cycles after the strobe is driven
      send_sample(16'h1234, 16'hABCD);
      check("t1_req_early", u_req, 0);
      check("t1_level", fifo_level, 1);
      @(negedge clk_50m);
      check("t1_req_rise", u_req, 1);
      check("t1_msg_const", u_msg, 64'h00ABCD1234000000);
      deliver(2, "t1");
      check("t1_level_empty", fifo_level, 0);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk_50m);
         seen |= u_req;
      end
      check("t1_single_msg", seen, 0);

      // Decimation by 3
      decim = 8'd2;
      do_reset();
      for (int i = 0; i < 9; i++) send_sample(16'(i), 16'hF000 + 16'(i));
      check("t2_level", fifo_level, 3);
      for (int i = 0; i < 3; i++) deliver(2, "t2");

      // Overflow with ack held low
      decim = 8'd0;
      do_reset();
      for (int i = 0; i < 7; i++) send_sample(16'h0100 + 16'(i), 16'h0200 + 16'(i));
      check("t3_level_full", fifo_level, 4);
      check("t3_drop", drop_cnt, {48'd0, m_drop});
      for (int i = 0; i < 4; i++) deliver(2, "t3");
      send_sample(16'h0777, 16'h0888);
      check("t3_seq_model", m_seq, 8);
      deliver(2, "t3_after");

      // Push in the same cycle as the ack-pop while full
      do_reset();
      for (int i = 0; i < 4; i++) send_sample(16'h0300 + 16'(i), 16'h0400 + 16'(i));
      wait_req("t4");
      exp = exp_q.pop_front();
      check("t4_head", u_msg, exp);
      smp_x     = 16'h0555;
      smp_y     = 16'h0666;
      smp_valid = 1'b1;
      u_ack     = 1'b1;
      model_sample(16'h0555, 16'h0666, 1);
      @(negedge clk_50m);
      smp_valid = 1'b0;
      check("t4_level", fifo_level, 4);
      check("t4_drop", drop_cnt, 0);
      check("t4_req_fall", u_req, 0);
      @(negedge clk_50m);
      u_ack = 1'b0;
      @(negedge clk_50m);
      for (int i = 0; i < 4; i++) deliver(2, "t4_drain");

      // Reset during S_REQ while the ack is held
      do_reset();
      send_sample(16'h0999, 16'h0AAA);
      wait_req("t5");
      rst   = 1'b1;
      u_ack = 1'b1;
      @(negedge clk_50m);
      rst = 1'b0;
      exp_q.delete();
      m_seq  = 8'd0;
      m_dcnt = 0;
      m_drop = 16'd0;
      check("t5_req_after_rst", u_req, 0);
      check("t5_level", fifo_level, 0);
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk_50m);
         seen |= u_req;
      end
      check("t5_req_during_ack", seen, 0);
      u_ack = 1'b0;
      seen  = 1'b0;
      repeat (5) begin
         @(negedge clk_50m);
         seen |= u_req;
      end
      check("t5_no_msg", seen, 0);

      // Enable low: pulses ignored, dcnt cleared, queued messages drain
      decim = 8'd1;
      do_reset();
      send_sample(16'h0A01, 16'h0B01);
      send_sample(16'h0A02, 16'h0B02);
      send_sample(16'h0A03, 16'h0B03);
      en = 1'b0;
      for (int i = 0; i < 3; i++) send_sample(16'h0C00 + 16'(i), 16'h0D00 + 16'(i));
      check("t6_level", fifo_level, 2);
      check("t6_seq_model", m_seq, 2);
      deliver(2, "t6_drain");
      deliver(3, "t6_drain");
      en = 1'b1;
      send_sample(16'h0A04, 16'h0B04);
      deliver(2, "t6_resume");

      // Drop counter saturation
      decim = 8'd0;
      do_reset();
      for (int i = 0; i < 4; i++) send_sample(16'h0E00 + 16'(i), 16'h0F00 + 16'(i));
      force dut.drop_cnt = 16'hFFFE;
      #1;
      release dut.drop_cnt;
      m_drop = 16'hFFFE;
      @(negedge clk_50m);
      check("t7_preset", drop_cnt, 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         send_sample(16'h0E10 + 16'(i), 16'h0F10 + 16'(i));
         check("t7_drop_sat", drop_cnt, {48'd0, m_drop});
      end
      check("t7_level", fifo_level, 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
